// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY counter-chain cells.
// Phase convention: enp = master sample (machine-clock rise),
// enn = slave transfer (machine-clock fall).
package pokey_pkg;

    // Value every cell latch takes on reset or functional clear.
    localparam logic CELL_RESET_VAL = 1'b0;

    // Names for the two phase enables, shared by all cell variants.
    typedef enum logic [0:0] {
        PH_MASTER_SAMPLE = 1'b0,  // enp
        PH_SLAVE_XFER    = 1'b1   // enn
    } phase_e;

    // Master next value for a toggle cell. Clear wins over toggle.
    function automatic logic cell_next(input logic clr, input logic tog, input logic s);
        if (clr) return CELL_RESET_VAL;
        return tog ? ~s : s;
    endfunction

endpackage

// File: rtl/cell_3_phase_latch_pair.sv
// Master/slave register pair clocked by two phase enables.
// The master loads m_i on enp. The slave copies the old master on enn.
// When both enables fire in one cycle, each side sees the other's old value.
module phase_latch_pair
    import pokey_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enp,
    input  logic enn,
    input  logic m_i,
    output logic m_o,
    output logic s_o
);

    logic m_q, m_d;
    logic s_q, s_d;

    // Enable muxes: each latch holds unless its phase enable is active.
    always_comb begin
        m_d = enp ? m_i : m_q;
        s_d = enn ? m_q : s_q;
    end

    // State registers. Reset clears both, so any pending toggle is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= CELL_RESET_VAL;
            s_q <= CELL_RESET_VAL;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign m_o = m_q;
    assign s_o = s_q;

    // Neither latch may move in a cycle without an enable.
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (!enp && !enn) |-> (m_d == m_q && s_d == s_q));

endmodule

// File: rtl/cell_3.sv
// One toggle stage of the POKEY divider/polynomial counter chain.
// Holds the next-state mux, the ripple-carry output and the complements.
module cell_3
    import pokey_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enp,
    input  logic enn,
    input  logic T1,
    input  logic nT1,
    input  logic R,
    output logic T2,
    output logic nT2,
    output logic Q,
    output logic nQ
);

    logic m_d, m_q, s_q;

    // nT1 is carried only for pin compatibility with the chain; T1 governs.
    logic nt1_unused;
    assign nt1_unused = nT1;

    // Master next value, computed from the current slave (old Q).
    always_comb begin
        m_d = cell_next(R, T1, s_q);
    end

    phase_latch_pair u_pair (
        .clk   (clk),
        .rst_n (rst_n),
        .enp   (enp),
        .enn   (enn),
        .m_i   (m_d),
        .m_o   (m_q),
        .s_o   (s_q)
    );

    // Stage value and up-count ripple carry, all combinational.
    assign Q   = s_q;
    assign nQ  = ~s_q;
    assign T2  = T1 & s_q;
    assign nT2 = ~T2;

    a_q_pair: assert property (@(posedge clk) Q == ~nQ);
    a_t_pair: assert property (@(posedge clk) T2 == ~nT2);

endmodule

// File: tb/tb_cell_3.sv
// Self-checking bench for cell_3: directed test-plan steps plus random
// phase/enable traffic checked against a two-phase behavioural model.
module tb_cell_3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enp = 1'b0, enn = 1'b0, T1 = 1'b0, nT1 = 1'b1, R = 1'b0;
    logic T2, nT2, Q, nQ;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: value captured at enp, visible on Q after enn.
    logic mdl_pend = 1'b0;
    logic mdl_q    = 1'b0;

    cell_3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enp   (enp),
        .enn   (enn),
        .T1    (T1),
        .nT1   (nT1),
        .R     (R),
        .T2    (T2),
        .nT2   (nT2),
        .Q     (Q),
        .nQ    (nQ)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".Q"},   Q,   mdl_q);
        chk({tag, ".nQ"},  nQ,  ~mdl_q);
        chk({tag, ".T2"},  T2,  T1 & mdl_q);
        chk({tag, ".nT2"}, nT2, ~(T1 & mdl_q));
    endtask

    // One clk cycle: drive at negedge, update model at posedge, check after.
    task automatic cyc(input logic p, input logic n, input logic r, input logic t, input string tag);
        logic new_pend, new_q;
        @(negedge clk);
        enp = p; enn = n; R = r; T1 = t; nT1 = ~t;
        #1 chk({tag, ".comb_T2"}, T2, t & mdl_q);
        @(posedge clk);
        new_q    = n ? mdl_pend : mdl_q;
        new_pend = mdl_pend;
        if (p) begin
            if (r)      new_pend = 1'b0;
            else if (t) new_pend = ~mdl_q;
            else        new_pend = mdl_q;
        end
        mdl_q = new_q;
        mdl_pend = new_pend;
        #1 chk_all(tag);
    endtask

    // Idle cycles with random (ignored) T1/R.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    endtask

    // One machine cycle: enp with r/t, gap, enn, gap.
    task automatic mc(input logic r, input logic t, input string tag);
        cyc(1'b1, 1'b0, r, t, {tag, ".enp"});
        idle(3, {tag, ".gap1"});
        cyc(1'b0, 1'b1, 1'b0, 1'b0, {tag, ".enn"});
        idle(3, {tag, ".gap2"});
    endtask

    // Asynchronous reset pulse: outputs checked before any clk edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        enp = 1'b0; enn = 1'b0; R = 1'b0; T1 = 1'b0; nT1 = 1'b1;
        #2 rst_n = 1'b0;
        mdl_q = 1'b0; mdl_pend = 1'b0;
        #1;
        chk({tag, ".Q"},   Q,   1'b0);
        chk({tag, ".nQ"},  nQ,  1'b1);
        chk({tag, ".T2"},  T2,  1'b0);
        chk({tag, ".nT2"}, nT2, 1'b1);
        @(posedge clk);
        #1 chk_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic p, n, r, t;

        // Reset state
        #5;
        chk("rst.Q", Q, 1'b0);
        chk("rst.nQ", nQ, 1'b1);
        chk("rst.T2", T2, 1'b0);
        chk("rst.nT2", nT2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, "post_rst");

        // Single toggle, then a second one back
        mc(1'b0, 1'b1, "tog1");  chk("tog1.const", Q, 1'b1);
        mc(1'b0, 1'b1, "tog2");  chk("tog2.const", Q, 1'b0);

        // Carry combinations
        mc(1'b0, 1'b1, "car_a");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "car11");
        chk("car11.T2", T2, 1'b1);  chk("car11.nT2", nT2, 1'b0);
        mc(1'b0, 1'b1, "car_b");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "car01");
        chk("car01.T2", T2, 1'b0);
        mc(1'b0, 1'b1, "car_c");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "car10");
        chk("car10.T2", T2, 1'b0);  chk("car10.Q", Q, 1'b1);

        // Clear from Q=1, then stays 0
        mc(1'b1, 1'b0, "clr");   chk("clr.const", Q, 1'b0);
        mc(1'b0, 1'b0, "clr_h"); chk("clr_h.const", Q, 1'b0);

        // R beats T1
        mc(1'b1, 1'b1, "prio");  chk("prio.const", Q, 1'b0);

        // T1 held across 4 enp pulses
        mc(1'b0, 1'b1, "hold1"); chk("hold1.const", Q, 1'b1);
        mc(1'b0, 1'b1, "hold2"); chk("hold2.const", Q, 1'b0);
        mc(1'b0, 1'b1, "hold3"); chk("hold3.const", Q, 1'b1);
        mc(1'b0, 1'b1, "hold4"); chk("hold4.const", Q, 1'b0);

        // Both enables in one cycle: slave takes old master
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "both");
        chk("both.const", Q, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "both_n");
        chk("both_n.const", Q, 1'b1);
        idle(2, "both_gap");

        // Mid-run reset with Q=1, then with a pending toggle
        async_reset("rst_mid");
        idle(2, "rst_mid_gap");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "pend");
        async_reset("rst_pend");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "pend_n");
        chk("pend_n.const", Q, 1'b0);

        // Random traffic, including occasional coincident enables
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 99) < 20);
            n = ($urandom_range(0, 99) < 20);
            r = ($urandom_range(0, 99) < 10);
            t = 1'($urandom_range(0, 1));
            cyc(p, n, r, t, "rnd");
        end

        @(negedge clk);
        enp = 1'b0; enn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
